// File: rtl/jpeg_enc_pkg.sv
// Shared types and constants for the JPEG entropy-encoder output path.
package jpeg_enc_pkg;

  localparam int ACC_W   = 64;
  localparam int MAX_LEN = 32;

  localparam logic [7:0] MARKER_BYTE = 8'hFF;
  localparam logic [7:0] STUFF_BYTE  = 8'h00;

  typedef enum logic {
    S_RUN   = 1'b0,
    S_STUFF = 1'b1
  } state_t;

  // Codes longer than MAX_LEN are treated as exactly MAX_LEN bits.
  function automatic logic [6:0] clamp_len(input logic [5:0] len);
    return (len > 6'(MAX_LEN)) ? 7'(MAX_LEN) : {1'b0, len};
  endfunction

endpackage

// File: rtl/jpeg_bitpacker.sv
// Packs right-aligned variable-length codes MSB-first into a byte stream,
// inserting 0x00 after every 0xFF and padding the final byte with 1s on flush.
module jpeg_bitpacker
  import jpeg_enc_pkg::*;
(
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        img_start_i,
  input  logic        inport_valid_i,
  input  logic [31:0] inport_data_i,
  input  logic [5:0]  inport_len_i,
  input  logic        inport_flush_i,
  output logic        inport_accept_o,
  output logic        outport_valid_o,
  output logic [7:0]  outport_data_o,
  output logic        outport_last_o,
  input  logic        outport_accept_i
);

  logic [ACC_W-1:0] acc_q, acc_next, acc_pop, code;
  logic [6:0]       count_q, count_next, count_pop, len_eff, shamt;
  logic             flush_q, flush_next;
  state_t           st_q, st_next;
  logic             stuff_last_q, stuff_last_next;

  logic             run_valid, run_last, out_hs, push;
  logic [7:0]       run_byte;

  // Output side is a pure decode of registered state.
  always_comb begin
    run_valid = (count_q >= 7'd8) || (flush_q && (count_q != 7'd0));
    run_byte  = acc_q[ACC_W-1 -: 8] |
                ((count_q < 7'd8) ? (8'hFF >> count_q[2:0]) : 8'h00);
    run_last  = flush_q && (count_q <= 7'd8) && (run_byte != MARKER_BYTE);
  end

  assign outport_valid_o = (st_q == S_STUFF) || run_valid;
  assign outport_data_o  = (st_q == S_STUFF) ? STUFF_BYTE :
                           (run_valid ? run_byte : 8'h00);
  assign outport_last_o  = (st_q == S_STUFF) ? stuff_last_q : (run_valid && run_last);
  assign inport_accept_o = !flush_q && (count_q <= 7'(MAX_LEN));

  always_comb begin
    len_eff         = clamp_len(inport_len_i);
    code            = {32'h0, inport_data_i} & ((64'd1 << len_eff) - 64'd1);
    out_hs          = outport_valid_o && outport_accept_i;
    push            = inport_valid_i && inport_accept_o;

    acc_pop         = acc_q;
    count_pop       = count_q;
    flush_next      = flush_q;
    st_next         = st_q;
    stuff_last_next = stuff_last_q;

    if (st_q == S_RUN) begin
      if (out_hs) begin
        acc_pop   = acc_q << 8;
        count_pop = (count_q >= 7'd8) ? (count_q - 7'd8) : 7'd0;
        if (run_byte == MARKER_BYTE) begin
          st_next         = S_STUFF;
          stuff_last_next = flush_q && (count_q <= 7'd8);
        end else if (run_last) begin
          acc_pop    = '0;
          count_pop  = 7'd0;
          flush_next = 1'b0;
        end
      end else if (flush_q && (count_q == 7'd0)) begin
        // Flush of an empty buffer: nothing to emit, just retire it.
        flush_next = 1'b0;
      end
    end else if (out_hs) begin
      st_next = S_RUN;
      if (stuff_last_q) begin
        acc_pop         = '0;
        count_pop       = 7'd0;
        flush_next      = 1'b0;
        stuff_last_next = 1'b0;
      end
    end

    // New code lands immediately below the bits that survive this cycle's pop.
    shamt      = 7'd64 - count_pop - len_eff;
    acc_next   = acc_pop;
    count_next = count_pop;
    if (push) begin
      acc_next   = acc_pop | (code << shamt);
      count_next = count_pop + len_eff;
      if (inport_flush_i) begin
        flush_next = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni || img_start_i) begin
      acc_q        <= '0;
      count_q      <= 7'd0;
      flush_q      <= 1'b0;
      st_q         <= S_RUN;
      stuff_last_q <= 1'b0;
    end else begin
      acc_q        <= acc_next;
      count_q      <= count_next;
      flush_q      <= flush_next;
      st_q         <= st_next;
      stuff_last_q <= stuff_last_next;
    end
  end

endmodule

// File: tb/tb_jpeg_bitpacker.sv
// Directed scoreboard bench for jpeg_bitpacker: expected bytes are queued with
// each stimulus step and compared as the sink consumes them.
module tb_jpeg_bitpacker;

  logic        clk = 1'b0;
  logic        rst_ni;
  logic        img_start;
  logic        in_valid;
  logic [31:0] in_data;
  logic [5:0]  in_len;
  logic        in_flush;
  logic        in_accept;
  logic        out_valid;
  logic [7:0]  out_data;
  logic        out_last;
  logic        out_accept;

  typedef struct packed {
    logic [7:0] data;
    logic       last;
  } exp_t;

  exp_t sb_q[$];
  exp_t mon_e;
  int   n_pass  = 0;
  int   n_total = 0;

  always #5 clk = ~clk;

  jpeg_bitpacker dut (
    .clk_i            (clk),
    .rst_ni           (rst_ni),
    .img_start_i      (img_start),
    .inport_valid_i   (in_valid),
    .inport_data_i    (in_data),
    .inport_len_i     (in_len),
    .inport_flush_i   (in_flush),
    .inport_accept_o  (in_accept),
    .outport_valid_o  (out_valid),
    .outport_data_o   (out_data),
    .outport_last_o   (out_last),
    .outport_accept_i (out_accept)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  task automatic expect_byte(input logic [7:0] d, input logic l);
    exp_t e;
    e.data = d;
    e.last = l;
    sb_q.push_back(e);
  endtask

  // Byte monitor: sampled on the falling edge, ahead of the transferring edge.
  always @(negedge clk) begin
    if (rst_ni && !img_start && out_valid && out_accept) begin
      if (sb_q.size() == 0) begin
        n_total++;
        $error("FAIL unexpected_byte: observed %02h expected none", out_data);
      end else begin
        mon_e = sb_q.pop_front();
        $display("byte %02h last=%0b (expected %02h last=%0b)",
                 out_data, out_last, mon_e.data, mon_e.last);
        check("byte_data", 32'(out_data), 32'(mon_e.data));
        check("byte_last", 32'(out_last), 32'(mon_e.last));
      end
    end
  end

  // Called and returns at posedge+1.
  task automatic push(input logic [31:0] d, input logic [5:0] l, input logic f);
    int budget;
    budget   = 0;
    in_valid = 1'b1;
    in_data  = d;
    in_len   = l;
    in_flush = f;
    while (!in_accept && budget < 200) begin
      @(posedge clk); #1;
      budget++;
    end
    if (!in_accept) begin
      n_total++;
      $error("FAIL push_timeout: observed accept=0 expected accept=1 within 200 cycles");
    end
    @(posedge clk); #1;
    $display("push %08h len %0d flush %0b", d, l, f);
    in_valid = 1'b0;
    in_flush = 1'b0;
  endtask

  task automatic wait_drain();
    int budget;
    budget = 0;
    while ((sb_q.size() != 0 || out_valid) && budget < 300) begin
      @(posedge clk); #1;
      budget++;
    end
    if (sb_q.size() != 0 || out_valid) begin
      n_total++;
      $error("FAIL drain_timeout: observed %0d bytes pending expected 0", sb_q.size());
    end
  endtask

  // Leaves a pending stuff byte plus 20 buffered bits, sink stalled.
  task automatic setup_pending();
    out_accept = 1'b1;
    expect_byte(8'hFF, 1'b0);
    push(32'h0000_00FF, 6'd8, 1'b0);
    @(posedge clk); #1;
    out_accept = 1'b0;
    check("stuff_pending_valid", 32'(out_valid), 32'd1);
    check("stuff_pending_data", 32'(out_data), 32'h00);
    push(32'h000A_BCDE, 6'd20, 1'b0);
  endtask

  task automatic check_cleared(input string tag);
    check({tag, "_valid"}, 32'(out_valid), 32'd0);
    check({tag, "_data"}, 32'(out_data), 32'h00);
    check({tag, "_last"}, 32'(out_last), 32'd0);
    check({tag, "_accept"}, 32'(in_accept), 32'd1);
  endtask

  initial begin
    rst_ni     = 1'b0;
    img_start  = 1'b0;
    in_valid   = 1'b0;
    in_data    = '0;
    in_len     = '0;
    in_flush   = 1'b0;
    out_accept = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst_ni = 1'b1;
    check_cleared("reset");

    // Two short codes merge into one byte.
    out_accept = 1'b1;
    expect_byte(8'hBF, 1'b0);
    push(32'h5, 6'd3, 1'b0);
    push(32'h1F, 6'd5, 1'b0);
    wait_drain();
    check("pack_idle_accept", 32'(in_accept), 32'd1);
    check("pack_idle_valid", 32'(out_valid), 32'd0);

    // Marker stuffing with an overlapping push/pop.
    expect_byte(8'hFF, 1'b0);
    expect_byte(8'h00, 1'b0);
    expect_byte(8'h12, 1'b0);
    push(32'hFF, 6'd8, 1'b0);
    push(32'h12, 6'd8, 1'b0);
    wait_drain();

    // Upper bits are masked off; oversize lengths clamp to 32.
    expect_byte(8'hA5, 1'b0);
    push(32'hFFFF_FFA5, 6'd8, 1'b0);
    expect_byte(8'h0F, 1'b0);
    expect_byte(8'h0F, 1'b0);
    expect_byte(8'h0F, 1'b0);
    expect_byte(8'h0F, 1'b0);
    push(32'h0F0F_0F0F, 6'd63, 1'b0);
    wait_drain();

    // Flush pads with 1s; accept stays low until the last byte is taken.
    out_accept = 1'b0;
    expect_byte(8'hBF, 1'b1);
    push(32'h2, 6'd2, 1'b1);
    check("flush_accept_low", 32'(in_accept), 32'd0);
    check("flush_hold_valid", 32'(out_valid), 32'd1);
    check("flush_hold_data", 32'(out_data), 32'hBF);
    check("flush_hold_last", 32'(out_last), 32'd1);
    out_accept = 1'b1;
    wait_drain();
    check("flush_accept_back", 32'(in_accept), 32'd1);

    // Padded final byte is 0xFF, so the stuff byte carries last.
    expect_byte(8'hFF, 1'b0);
    expect_byte(8'h00, 1'b1);
    push(32'h7F, 6'd7, 1'b1);
    wait_drain();
    check("flush_ff_accept_back", 32'(in_accept), 32'd1);

    // Empty flush emits nothing and retires after one cycle.
    push(32'h0, 6'd0, 1'b1);
    check("empty_flush_valid", 32'(out_valid), 32'd0);
    check("empty_flush_accept_low", 32'(in_accept), 32'd0);
    @(posedge clk); #1;
    check("empty_flush_valid2", 32'(out_valid), 32'd0);
    check("empty_flush_accept_back", 32'(in_accept), 32'd1);

    // Backpressure: fill to 64 bits, then release the sink.
    out_accept = 1'b0;
    expect_byte(8'h12, 1'b0);
    expect_byte(8'h34, 1'b0);
    expect_byte(8'h56, 1'b0);
    expect_byte(8'h78, 1'b0);
    expect_byte(8'h9A, 1'b0);
    expect_byte(8'hBC, 1'b0);
    expect_byte(8'hDE, 1'b0);
    expect_byte(8'hF0, 1'b0);
    check("bp_accept_first", 32'(in_accept), 32'd1);
    push(32'h1234_5678, 6'd32, 1'b0);
    check("bp_accept_at_32", 32'(in_accept), 32'd1);
    push(32'h9ABC_DEF0, 6'd32, 1'b0);
    check("bp_accept_full", 32'(in_accept), 32'd0);
    for (int i = 0; i < 3; i++) begin
      check("bp_stall_valid", 32'(out_valid), 32'd1);
      check("bp_stall_data", 32'(out_data), 32'h12);
      @(posedge clk); #1;
    end
    out_accept = 1'b1;
    repeat (3) @(posedge clk);
    #1 check("bp_accept_at_40", 32'(in_accept), 32'd0);
    @(posedge clk); #1;
    check("bp_accept_at_32_again", 32'(in_accept), 32'd1);
    wait_drain();

    // img_start wins over a same-cycle push and drops the pending stuff byte.
    setup_pending();
    img_start = 1'b1;
    in_valid  = 1'b1;
    in_data   = 32'h55;
    in_len    = 6'd8;
    @(posedge clk); #1;
    img_start = 1'b0;
    in_valid  = 1'b0;
    check_cleared("img_start");
    out_accept = 1'b1;
    expect_byte(8'hA5, 1'b0);
    push(32'hA5, 6'd8, 1'b0);
    wait_drain();

    // Same scenario cleared by reset.
    setup_pending();
    rst_ni = 1'b0;
    @(posedge clk); #1;
    rst_ni = 1'b1;
    check_cleared("rst");
    out_accept = 1'b1;
    expect_byte(8'hA5, 1'b0);
    push(32'hA5, 6'd8, 1'b0);
    wait_drain();

    check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
